muldiv_unit: RTL and testbench

- Sequential multiply/divide unit that owns the architectural HI/LO registers of the MIPS-style core.
- Executes MULT, MULTU, DIV and DIVU issued by the execute stage and holds the pipeline with a busy/stall handshake.
- Services MTHI/MTLO writes and drives HI/LO continuously for MFHI/MFLO.
- The combinational ALU no longer has to produce 64-bit or quotient/remainder results in a single cycle.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_unit_div_iter.sv | 28 ++
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
// The core decoder uses the same op codes, so MULT/MULTU/DIV/DIVU share one
// encoding across the pipeline. Contents: op codes, FSM state encoding and
// default widths.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam int WIDTH_DEFAULT     = 32;
  localparam int DIV_ITERS_DEFAULT = WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: one combinational restoring-division step.
// Ports:
//   rem_in  - current partial remainder (WIDTH+1 bits)
//   dvd_bit - next dividend bit shifted into the remainder
//   divisor - divisor magnitude
//   rem_out - partial remainder after this step
//   q_bit   - quotient bit produced by this step
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] diff_s;

  assign shifted_s = {rem_in[WIDTH-1:0], dvd_bit};
  assign diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
  // A set rem_in MSB means the true shifted value exceeds any divisor, so the
  // subtraction always succeeds; otherwise the borrow bit decides.
  assign q_bit     = rem_in[WIDTH] | ~diff_s[WIDTH+1];
  assign rem_out   = q_bit ? diff_s[WIDTH:0] : shifted_s;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential multiply/divide unit owning the HI/LO registers.
// MULT/MULTU complete in one busy cycle; DIV/DIVU run a restoring divider for
// DIV_ITERS cycles followed by a sign-fix cycle. HI/LO are also written by
// MTHI/MTLO while idle and are read continuously for MFHI/MFLO.
// Ports:
//   clk, rst            - clock, async active-high reset
//   start, op           - issue request and operation (MULT/MULTU/DIV/DIVU)
//   src1, src2          - rs / rt operands, captured on issue
//   flush               - abort in-flight operation, blocks a same-cycle issue
//   hi_we, lo_we, wdata - MTHI/MTLO write port (idle only)
//   busy, stall         - FSM not idle; stall also covers a pending issue
//   done                - one-cycle pulse alongside the new HI/LO values
//   hi, lo              - architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int DIV_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CNT_W    = $clog2(DIV_ITERS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  state_e             state_r, state_nxt_s;
  logic               issue_s, finish_s;
  logic               src1_neg_s, src2_neg_s;
  logic               mul_signed_r, sign_q_r, sign_rem_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [WIDTH:0]     rem_r, rem_nxt_s;
  logic               q_bit_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] mul_a_s, mul_b_s, product_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s, res_hi_s, res_lo_s;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               done_r;

  assign busy  = (state_r != ST_IDLE);
  assign stall = busy | (start & ~flush);
  assign done  = done_r;
  assign hi    = hi_r;
  assign lo    = lo_r;

  // Only signed DIV works on magnitudes; for every other op these stay low so
  // the operands are captured unchanged.
  assign src1_neg_s = (op == OP_DIV) & src1[WIDTH-1];
  assign src2_neg_s = (op == OP_DIV) & src2[WIDTH-1];

  // Sign/zero extension to 2*WIDTH makes one multiplier serve both MULT and
  // MULTU: the low 2*WIDTH bits of the product are correct either way.
  assign mul_a_s   = {{WIDTH{mul_signed_r & a_r[WIDTH-1]}}, a_r};
  assign mul_b_s   = {{WIDTH{mul_signed_r & b_r[WIDTH-1]}}, b_r};
  assign product_s = mul_a_s * mul_b_s;

  // After the last iteration a_r holds the quotient magnitude.
  assign quo_fix_s = sign_q_r   ? ({WIDTH{1'b0}} - a_r)              : a_r;
  assign rem_fix_s = sign_rem_r ? ({WIDTH{1'b0}} - rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .rem_in  (rem_r),
    .dvd_bit (a_r[WIDTH-1]),
    .divisor (b_r),
    .rem_out (rem_nxt_s),
    .q_bit   (q_bit_s)
  );

  // Completion result select: product in MUL, sign-fixed quotient/remainder otherwise.
  always_comb begin
    res_hi_s = rem_fix_s;
    res_lo_s = quo_fix_s;
    if (state_r == ST_MUL) begin
      {res_hi_s, res_lo_s} = product_s;
    end else begin
      res_hi_s = rem_fix_s;
      res_lo_s = quo_fix_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state, issue and completion decode.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !flush) begin
          issue_s     = 1'b1;
          state_nxt_s = op[1] ? ST_DIV : ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        state_nxt_s = ST_IDLE;
        if (flush) begin
          finish_s = 1'b0;
        end else begin
          finish_s = 1'b1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      ST_FIX: begin
        state_nxt_s = ST_IDLE;
        if (flush) begin
          finish_s = 1'b0;
        end else begin
          finish_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture on issue and one restoring step per DIV cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      rem_r        <= {(WIDTH+1){1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      mul_signed_r <= 1'b0;
      sign_q_r     <= 1'b0;
      sign_rem_r   <= 1'b0;
    end else if (issue_s) begin
      a_r          <= src1_neg_s ? ({WIDTH{1'b0}} - src1) : src1;
      b_r          <= src2_neg_s ? ({WIDTH{1'b0}} - src2) : src2;
      rem_r        <= {(WIDTH+1){1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      mul_signed_r <= (op == OP_MULT);
      sign_q_r     <= src1_neg_s ^ src2_neg_s;
      sign_rem_r   <= src1_neg_s;
    end else if (state_r == ST_DIV) begin
      // Dividend bits leave at the top of a_r while quotient bits enter at the bottom.
      rem_r <= rem_nxt_s;
      a_r   <= {a_r[WIDTH-2:0], q_bit_s};
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // HI/LO registers and done pulse: completion write, else MTHI/MTLO while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      done_r <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (finish_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else if (state_r == ST_IDLE) begin
        if (hi_we) hi_r <= wdata;
        if (lo_we) lo_r <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Issued operations push the
// expected {hi, lo} and completion cycle into a queue; a monitor pops and
// compares on every done pulse. Random operations use an arithmetic reference.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W       = 32;
  localparam int LAT_MUL = 2;
  localparam int LAT_DIV = 34;

  logic         clk = 1'b0;
  logic         rst, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] src1, src2, wdata;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       p;
    int           sa, sb_v;
    logic [63:0]  u;
    case (o)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      OP_MULTU: begin
        u = {32'd0, a} * {32'd0, b};
        return u;
      end
      OP_DIV: begin
        if (b == 32'd0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa   = a;
        sb_v = b;
        return {32'(sa % sb_v), 32'(sa / sb_v)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        chk("done_gap", {63'd0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cycle=%0d hi=%h lo=%h", cyc, hi, lo);
        end else begin
          mon_e = sb.pop_front();
          chk("result_hi", {32'd0, hi}, {32'd0, mon_e.hi});
          chk("result_lo", {32'd0, lo}, {32'd0, mon_e.lo});
          chk("latency", cyc, mon_e.cyc);
        end
      end
      prev_done = done;
    end
  end

  // Issue one operation from a negedge; returns one cycle after the start pulse.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", {63'd0, busy}, 64'd0);
    start = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    if (push) sb.push_back('{eh, el, cyc + (o[1] ? LAT_DIV : LAT_MUL)});
    #1 chk("stall_on_issue", {63'd0, stall}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    src1  = $urandom;
    src2  = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 64'd0);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    logic [63:0]  r;

    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; src1 = 32'd0; src2 = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic vectors.
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    chk("mul_busy_c1", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("mul_busy_c2", {63'd0, busy}, 64'd0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(OP_DIVU,  32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    issue(OP_DIVU,  32'd100, 32'd0, 1'b1, 32'h0000_0064, 32'hFFFF_FFFF);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0001);
    wait_drain();

    // MTHI / MTLO while idle.
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", {32'd0, hi}, 64'h1234);
    lo_we = 1'b1; wdata = 32'h0000_5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", {32'd0, lo}, 64'h5678);

    // Flush mid-divide: no done, HI/LO kept.
    issue(OP_DIV, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    // Start alongside flush in idle is dropped.
    start = 1'b1; flush = 1'b1; op = OP_MULT;
    #1 chk("flush_start_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hi", {32'd0, hi}, 64'h1234);
    chk("flush_lo", {32'd0, lo}, 64'h5678);

    // start and MTHI/MTLO while busy are ignored.
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_MULT; src1 = 32'd3; src2 = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    chk("busy_we_hi", {32'd0, hi}, 64'h1234);
    chk("busy_we_lo", {32'd0, lo}, 64'h5678);
    wait_drain();

    // start together with MTHI: MTHI visible until completion.
    hi_we = 1'b1; wdata = 32'h0000_ABCD;
    issue(OP_MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
    chk("start_mthi_hi", {32'd0, hi}, 64'hABCD);
    wait_drain();

    // Asynchronous reset mid-divide.
    issue(OP_DIV, 32'd12345, 32'd7, 1'b0, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(OP_MULT, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42);
    wait_drain();

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      r  = ref_model(ro, ra, rb);
      issue(ro, ra, rb, 1'b1, r[63:32], r[31:0]);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
